// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, h/v counters, sync/bright decode and frame counter.
// Outputs are registered from the next-state counters so sync and bright line up with hCount/vCount.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 515
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        pix_tick,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] H_VS_C   = 10'(H_VIS_START);
  localparam logic [9:0] H_VE_C   = 10'(H_VIS_END);
  localparam logic [9:0] V_VS_C   = 10'(V_VIS_START);
  localparam logic [9:0] V_VE_C   = 10'(V_VIS_END);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          tick_q, tick_d;
  logic          hs_q, hs_d, vs_q, vs_d, br_q, br_d;
  logic          fs_q, fs_d;
  logic [15:0]   fc_q, fc_d;

  always_comb begin
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    tick_d = 1'b0;
    fs_d   = 1'b0;
    fc_d   = fc_q;
    if (en) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d  = '0;
            fs_d = 1'b1;
            fc_d = fc_q + 16'd1;
          end else begin
            v_d = v_q + 10'd1;
          end
        end else begin
          h_d = h_q + 10'd1;
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    // Decode from next-state counters so the registered flags carry no skew.
    hs_d = (h_d >= H_SYNC_C);
    vs_d = (v_d >= V_SYNC_C);
    br_d = (h_d >= H_VS_C) && (h_d < H_VE_C) && (v_d >= V_VS_C) && (v_d < V_VE_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      tick_q <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      br_q   <= 1'b0;
      fs_q   <= 1'b0;
      fc_q   <= '0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      tick_q <= tick_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      br_q   <= br_d;
      fs_q   <= fs_d;
      fc_q   <= fc_d;
    end
  end

  assign pix_tick    = tick_q;
  assign hCount      = h_q;
  assign vCount      = v_q;
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign bright      = br_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance, a tiny 10x5 raster, and a 1x1 raster for frame_count wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, rst_c_n, en_a, en_b, en_c;

  logic        pt_a, hs_a, vs_a, br_a, fs_a;
  logic [9:0]  h_a, v_a;
  logic [15:0] fc_a;
  logic        pt_b, hs_b, vs_b, br_b, fs_b;
  logic [9:0]  h_b, v_b;
  logic [15:0] fc_b;
  logic        pt_c, hs_c, vs_c, br_c, fs_c;
  logic [9:0]  h_c, v_c;
  logic [15:0] fc_c;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_a_n), .en(en_a), .pix_tick(pt_a), .hCount(h_a), .vCount(v_a),
    .hSync(hs_a), .vSync(vs_a), .bright(br_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(10), .H_SYNC(2), .H_VIS_START(3), .H_VIS_END(8),
    .V_TOTAL(5), .V_SYNC(1), .V_VIS_START(1), .V_VIS_END(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .en(en_b), .pix_tick(pt_b), .hCount(h_b), .vCount(v_b),
    .hSync(hs_b), .vSync(vs_b), .bright(br_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(1), .H_SYNC(1), .H_VIS_START(1), .H_VIS_END(1),
    .V_TOTAL(1), .V_SYNC(1), .V_VIS_START(1), .V_VIS_END(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_c_n), .en(en_c), .pix_tick(pt_c), .hCount(h_c), .vCount(v_c),
    .hSync(hs_c), .vSync(vs_c), .bright(br_c), .frame_start(fs_c), .frame_count(fc_c)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   base_b = 0;

  function automatic string fname(input int f);
    case (f)
      0: return "pix_tick";
      1: return "hCount";
      2: return "vCount";
      3: return "hSync";
      4: return "vSync";
      5: return "bright";
      6: return "frame_start";
      default: return "frame_count";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] r;
    r = '0;
    case (sel)
      0:  r = 32'(pt_a);
      1:  r = 32'(h_a);
      2:  r = 32'(v_a);
      3:  r = 32'(hs_a);
      4:  r = 32'(vs_a);
      5:  r = 32'(br_a);
      6:  r = 32'(fs_a);
      7:  r = 32'(fc_a);
      10: r = 32'(pt_b);
      11: r = 32'(h_b);
      12: r = 32'(v_b);
      13: r = 32'(hs_b);
      14: r = 32'(vs_b);
      15: r = 32'(br_b);
      16: r = 32'(fs_b);
      17: r = 32'(fc_b);
      20: r = 32'(pt_c);
      21: r = 32'(h_c);
      22: r = 32'(v_c);
      26: r = 32'(fs_c);
      27: r = 32'(fc_c);
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  task automatic push(input string t, input int sel, input int v);
    exp_t e;
    e.tag = $sformatf("%s.%s", t, fname(sel % 10));
    e.sel = sel;
    e.exp = 32'(v);
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      tests++;
      assert (o === e.exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Timing snapshot for the default instance, compared against the DUT at cycle 'at'.
  task automatic exp_a(input int at, input int pt, input int h, input int v,
                       input int hs, input int vs, input int br);
    string t;
    t = $sformatf("a@%0d", at);
    push(t, 0, pt);
    push(t, 1, h);
    push(t, 2, v);
    push(t, 3, hs);
    push(t, 4, vs);
    push(t, 5, br);
    run_to(at);
    check_sb();
  endtask

  // Reference raster for the 10x5, CLK_DIV=1 instance: pixel index equals cycles since release.
  task automatic run_b(input int n);
    int    cb, h, v;
    string t;
    for (int i = 0; i < n; i++) begin
      cb = cyc + 1 - base_b;
      h  = cb % 10;
      v  = (cb / 10) % 5;
      t  = $sformatf("b@%0d", cb);
      push(t, 10, 1);
      push(t, 11, h);
      push(t, 12, v);
      push(t, 13, (h >= 2) ? 1 : 0);
      push(t, 14, (v >= 1) ? 1 : 0);
      push(t, 15, (h >= 3 && h < 8 && v >= 1 && v < 4) ? 1 : 0);
      push(t, 16, (cb % 50 == 0) ? 1 : 0);
      push(t, 17, cb / 50);
      tick();
      check_sb();
    end
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int s = 0; s < 8; s++) push("a.reset", s, 0);
    for (int s = 10; s < 18; s++) push("b.reset", s, 0);
    check_sb();

    rst_a_n = 1'b1;
    rst_c_n = 1'b1;
    cyc = 0;

    exp_a(3, 0, 0, 0, 0, 0, 0);
    push("a@3", 6, 0);
    push("a@3", 7, 0);
    push("c@3", 26, 1);
    push("c@3", 27, 3);
    check_sb();
    exp_a(4, 1, 1, 0, 0, 0, 0);
    exp_a(5, 0, 1, 0, 0, 0, 0);
    exp_a(383, 0, 95, 0, 0, 0, 0);
    exp_a(384, 1, 96, 0, 1, 0, 0);
    exp_a(3199, 0, 799, 0, 1, 0, 0);
    push("a@3200", 6, 0);
    exp_a(3200, 1, 0, 1, 0, 0, 0);

    exp_a(4400, 1, 300, 1, 1, 0, 0);
    exp_a(4401, 0, 300, 1, 1, 0, 0);
    en_a = 1'b0;
    exp_a(4404, 0, 300, 1, 1, 0, 0);
    exp_a(4411, 0, 300, 1, 1, 0, 0);
    en_a = 1'b1;
    exp_a(4413, 0, 300, 1, 1, 0, 0);
    exp_a(4414, 1, 301, 1, 1, 0, 0);
    exp_a(6409, 0, 799, 1, 1, 0, 0);
    push("a@6410", 6, 0);
    push("a@6410", 7, 0);
    exp_a(6410, 1, 0, 2, 0, 1, 0);

    rst_b_n = 1'b1;
    base_b  = cyc;
    run_b(133);

    rst_b_n = 1'b0;
    #1;
    for (int s = 10; s < 18; s++) push("b.async_clr", s, 0);
    check_sb();
    tick();
    for (int s = 10; s < 18; s++) push("b.held", s, 0);
    check_sb();
    rst_b_n = 1'b1;
    base_b  = cyc;
    run_b(101);

    push("c@65535", 27, 65535);
    push("c@65535", 26, 1);
    run_to(65535);
    check_sb();
    push("c@65536", 27, 0);
    push("c@65536", 26, 1);
    push("c@65536", 21, 0);
    push("c@65536", 22, 0);
    tick();
    check_sb();
    push("c@65537", 27, 1);
    tick();
    check_sb();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
